// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, optional two's-complement mode.
// Results and flags are held from completion until the next accepted start.
module seq_divider #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned TW = WIDTH + 2;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   prem;
  logic             neg_q;
  logic             neg_r;
  logic             ovf_pend;

  logic             sgn_mode_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [TW-1:0]    trial_c;
  logic             trial_ge_c;

  // Operand magnitudes and one restoring trial step
  always_comb begin
    sgn_mode_c = (SIGNED_EN != 0) && is_signed;
    a_neg_c    = sgn_mode_c && dividend[WIDTH-1];
    b_neg_c    = sgn_mode_c && divisor[WIDTH-1];
    mag_a_c    = a_neg_c ? -dividend : dividend;
    mag_b_c    = b_neg_c ? -divisor : divisor;
    trial_c    = {prem, dvd_sh[WIDTH-1]};
    trial_ge_c = (trial_c >= TW'(dvs));
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (divisor == '0) ? DONE : ITER;
      ITER:  if (cnt == CW'(1)) state_nxt = FIXUP;
      FIXUP: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and registered outputs; done trails the DONE state by one edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      dvd_sh      <= '0;
      dvs         <= '0;
      prem        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            dvd_sh      <= mag_a_c;
            dvs         <= mag_b_c;
            prem        <= '0;
            cnt         <= CW'(WIDTH);
            neg_q       <= a_neg_c ^ b_neg_c;
            neg_r       <= a_neg_c;
            ovf_pend    <= sgn_mode_c && (dividend == MIN_NEG) && (divisor == '1);
            ovf         <= 1'b0;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        ITER: begin
          prem   <= (WIDTH+1)'(trial_ge_c ? (trial_c - TW'(dvs)) : trial_c);
          dvd_sh <= {dvd_sh[WIDTH-2:0], trial_ge_c};
          cnt    <= cnt - CW'(1);
        end
        FIXUP: begin
          quotient  <= neg_q ? -dvd_sh : dvd_sh;
          remainder <= neg_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
          ovf       <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider against an integer-arithmetic reference.
module tb_seq_divider;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {div_by_zero, ovf, quotient, remainder} from plain integer division
  function automatic logic [33:0] model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, sq, sr;
    int unsigned ua, ub;
    if (b == 0) return {1'b1, 1'b0, 16'hFFFF, a};
    if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -32768 && sb == -1) return {1'b0, 1'b1, 16'h8000, 16'h0000};
      sq = sa / sb;
      sr = sa % sb;
      return {1'b0, 1'b0, 16'(sq), 16'(sr)};
    end
    ua = 32'(a);
    ub = 32'(b);
    return {1'b0, 1'b0, 16'(ua / ub), 16'(ua % ub)};
  endfunction

  task automatic run_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke, input string tag);
    logic [33:0] exp;
    int lat, k, extra;
    exp = model(sgn, a, b);
    lat = (b == 0) ? 1 : W + 2;
    @(negedge clk);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; is_signed = 1'($urandom); dividend = 16'($urandom); divisor = 16'($urandom);
    check({tag, ".busy_e"}, 32'(busy), 32'd1);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(posedge clk); #1;
      if (poke && i == 3) begin
        start = 1'b1; is_signed = 1'($urandom); dividend = 16'($urandom); divisor = 16'($urandom);
      end
      if (poke && i == 4) start = 1'b0;
      if (done) k = i;
    end
    check({tag, ".lat"}, 32'(k), 32'(lat));
    if (k != 0) begin
      check({tag, ".q"}, 32'(quotient), 32'(exp[31:16]));
      check({tag, ".r"}, 32'(remainder), 32'(exp[15:0]));
      check({tag, ".flags"}, 32'({div_by_zero, ovf}), 32'(exp[33:32]));
      check({tag, ".busy_d"}, 32'(busy), 32'd0);
      extra = 0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check({tag, ".pulses"}, 32'(extra), 32'd0);
      check({tag, ".hold"}, 32'({div_by_zero, ovf, quotient, remainder}), 32'(exp));
    end
  endtask

  initial begin
    int dcnt;
    logic [W-1:0] a, b;
    bit sgn;
    int sel;
    rst = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    #1;
    check("rst.q", 32'(quotient), 32'd0);
    check("rst.ctl", 32'({busy, done, div_by_zero, ovf}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_div(1'b0, 16'd100, 16'd7, 1'b0, "u100_7");
    run_div(1'b1, 16'hFFF9, 16'h0002, 1'b0, "s-7_2");
    run_div(1'b0, 16'hFFF9, 16'h0002, 1'b0, "u-7_2");
    run_div(1'b1, 16'h04D2, 16'h0000, 1'b0, "dz");
    run_div(1'b1, 16'h8000, 16'hFFFF, 1'b0, "ovf");
    run_div(1'b0, 16'h8000, 16'hFFFF, 1'b0, "u8000");
    run_div(1'b1, 16'h7FFF, 16'h0001, 1'b0, "smax");
    run_div(1'b0, 16'h1234, 16'h0056, 1'b1, "poke");

    // Reset five edges into an operation
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 16'd4321; divisor = 16'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst.q", 32'(quotient), 32'd0);
    check("arst.r", 32'(remainder), 32'd0);
    check("arst.ctl", 32'({busy, done, div_by_zero, ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("arst.nodone", 32'(dcnt), 32'd0);
    run_div(1'b0, 16'd1000, 16'd10, 1'b0, "post_rst");

    for (int n = 0; n < 60; n++) begin
      sgn = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 16'h8000; b = 16'hFFFF; end
      else if (sel == 2) b = 16'($urandom_range(1, 3));
      else if (sel == 3) b = -16'($urandom_range(1, 3));
      run_div(sgn, a, b, (sel == 4), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand, quotient and remainder width; legal range is 4..32.
REQ-002 SHALL have parameter SIGNED_EN, default 1; when 0, is_signed is ignored and all divisions are unsigned.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-006 SHALL have port is_signed, input, 1 bit: 1 selects two's-complement division; sampled with start.
REQ-007 SHALL have port dividend, input, WIDTH bits: dividend, captured when start is accepted.
REQ-008 SHALL have port divisor, input, WIDTH bits: divisor, captured when start is accepted.
REQ-009 SHALL have port quotient, output, WIDTH bits: registered quotient result.
REQ-010 SHALL have port remainder, output, WIDTH bits: registered remainder result.
REQ-011 SHALL have port busy, output, 1 bit: high from the accepting edge until DONE is left.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse while results are first valid.
REQ-013 SHALL have port div_by_zero, output, 1 bit: result flag, divisor was 0.
REQ-014 SHALL have port ovf, output, 1 bit: result flag, signed most-negative / -1 occurred.

Function
REQ-015 SHALL implement FSM states IDLE, ITER, FIXUP and DONE.
REQ-016 SHALL accept start only in IDLE; start in any other state SHALL be ignored and SHALL NOT corrupt the operation in flight.
REQ-017 SHALL, on the accepting edge: capture the operand magnitudes, capture the operand signs (signed mode only), clear the partial remainder, load the iteration counter with WIDTH, clear both flags, and go to ITER (divisor != 0) or DONE (divisor == 0).
REQ-018 SHALL perform one restoring shift-subtract iteration per cycle in ITER using a WIDTH+1-bit partial remainder, producing one quotient bit MSB-first, for exactly WIDTH cycles, then go to FIXUP.
REQ-019 SHALL, in FIXUP, produce the final results: quotient is negated when the operand signs differ; remainder is negated when the dividend is negative; quotient truncates toward zero; the remainder sign follows the dividend.
REQ-020 SHALL spend exactly one cycle in DONE with done=1, then return to IDLE; a start sampled in the DONE cycle SHALL be ignored.
REQ-021 SHALL give a latency, for a nonzero divisor, of done high in the cycle after edge E+WIDTH+2, where E is the accepting edge.
REQ-022 SHALL, for divisor == 0: set quotient to all ones, remainder to the raw dividend and div_by_zero=1, with done high in the cycle after edge E+1; ovf SHALL be 0.
REQ-023 SHALL, for signed mode with dividend = 2^(WIDTH-1) and divisor = -1: set quotient to 2^(WIDTH-1) (wrapped), remainder to 0 and ovf=1, with normal latency.
REQ-024 SHALL hold quotient, remainder, div_by_zero and ovf stable from DONE until the next accepted start.
REQ-025 SHALL keep busy=1 in ITER, FIXUP and DONE, and busy=0 in IDLE.
REQ-026 SHALL treat operands as unsigned when is_signed=0 or SIGNED_EN=0.

Reset
REQ-027 SHALL, while rst=0, immediately force: state IDLE; quotient, remainder, busy, done, div_by_zero and ovf to 0; counter and internal registers cleared.
REQ-028 SHALL, when rst is asserted mid-operation, abandon the operation with no done pulse; the first start after rst returns high SHALL be processed normally.

Verification (WIDTH=16)
REQ-029 SHALL cover unsigned 100/7 -> quotient 0x000E, remainder 0x0002, done high after edge E+18, both flags 0.
REQ-030 SHALL cover signed -7/2 (0xFFF9/0x0002) -> quotient 0xFFFD, remainder 0xFFFF; and the same operands with is_signed=0 -> quotient 0x7FFC, remainder 0x0001.
REQ-031 SHALL cover 0x04D2/0 -> quotient 0xFFFF, remainder 0x04D2, div_by_zero=1, done high after edge E+1.
REQ-032 SHALL cover signed 0x8000/0xFFFF -> quotient 0x8000, remainder 0x0000, ovf=1.
REQ-033 SHALL cover start pulsed during ITER with different operands -> the original result is unchanged and exactly one done pulse occurs.
REQ-034 SHALL cover rst low at E+5 -> all outputs 0 at once and no done; then 1000/10 -> quotient 0x0064, remainder 0.
